// File: rtl/ate_pkg.sv
// Shared types and constants for the adaptive threshold engine frame sequencer.
package ate_pkg;
  localparam int unsigned BLK_PIX  = 64;
  localparam int unsigned BLK_DIM  = 8;
  localparam int unsigned CORE_LAT = 64;
  localparam int unsigned PIX_W    = 8;

  typedef enum logic [1:0] {IDLE, ALIGN, FEED, DRAIN} state_t;
endpackage

// File: rtl/ate_frame_ctrl_if.sv
// Bus bundle between the frame sequencer, image/result/threshold memories and the ate core.
interface ate_frame_ctrl_if
  import ate_pkg::*;
#(
  parameter int unsigned AW = 11,
  parameter int unsigned BW = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic [AW-1:0]    img_addr;
  logic             img_rd;
  logic [PIX_W-1:0] img_data;
  logic             ate_reset;
  logic [PIX_W-1:0] ate_pix;
  logic             ate_bin;
  logic [PIX_W-1:0] ate_thr;
  logic             res_we;
  logic [AW-1:0]    res_addr;
  logic             res_data;
  logic             thr_we;
  logic [BW-1:0]    thr_addr;
  logic [PIX_W-1:0] thr_data;

  modport master (
    input  start, img_data, ate_bin, ate_thr,
    output busy, done, img_addr, img_rd, ate_reset, ate_pix,
           res_we, res_addr, res_data, thr_we, thr_addr, thr_data
  );

  modport slave (
    output start, img_data, ate_bin, ate_thr,
    input  busy, done, img_addr, img_rd, ate_reset, ate_pix,
           res_we, res_addr, res_data, thr_we, thr_addr, thr_data
  );
endinterface

// File: rtl/ate_blk_addr_gen.sv
// Walks an image in 8x8-block order (c, r, bx, by) and tracks the matching raster address
// and block index; one step per asserted step cycle, wrapping to pixel 0 after the last pixel.
module ate_blk_addr_gen
  import ate_pkg::*;
#(
  parameter int unsigned BLK_W = 6,
  parameter int unsigned BLK_H = 4,
  parameter int unsigned AW    = 11,
  parameter int unsigned BW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic [BW-1:0] blk,
  output logic          at_last_c
);
  localparam int unsigned ROW_PIX = BLK_DIM * BLK_W;
  localparam logic [BW-1:0] BX_LAST = BW'(BLK_W - 1);
  localparam logic [BW-1:0] BY_LAST = BW'(BLK_H - 1);

  logic [2:0]    c;
  logic [2:0]    r;
  logic [BW-1:0] bx;
  logic [BW-1:0] by;

  assign at_last_c = (c == 3'd7) && (r == 3'd7) && (bx == BX_LAST) && (by == BY_LAST);

  // Address is stepped incrementally: +1 along a block row, jump to next row, next block or next band.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      c    <= '0;
      r    <= '0;
      bx   <= '0;
      by   <= '0;
      blk  <= '0;
      addr <= '0;
    end else if (step) begin
      c <= c + 3'd1;
      if (c != 3'd7) begin
        addr <= addr + AW'(1);
      end else begin
        r <= r + 3'd1;
        if (r != 3'd7) begin
          addr <= addr + AW'(ROW_PIX - 7);
        end else begin
          blk <= blk + BW'(1);
          if (bx != BX_LAST) begin
            bx   <= bx + BW'(1);
            addr <= addr - AW'(7 * ROW_PIX - 1);
          end else begin
            bx <= '0;
            if (by != BY_LAST) begin
              by   <= by + BW'(1);
              addr <= addr + AW'(1);
            end else begin
              by   <= '0;
              blk  <= '0;
              addr <= '0;
            end
          end
        end
      end
    end
  end
endmodule

// File: rtl/ate_frame_ctrl.sv
// Frame sequencer: streams an image to the ate core in block order, then writes back
// the delayed bin bits and per-block thresholds, flushing the core after the last pixel.
module ate_frame_ctrl
  import ate_pkg::*;
#(
  parameter int unsigned BLK_W = 6,
  parameter int unsigned BLK_H = 4,
  parameter int unsigned AW    = 11,
  parameter int unsigned BW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  ate_frame_ctrl_if.master bus
);
  localparam int unsigned NPIX = BLK_PIX * BLK_W * BLK_H;
  localparam int unsigned SW   = AW + 1;
  localparam logic [SW-1:0] S_FEED_LAST = SW'(NPIX - 1);
  localparam logic [SW-1:0] S_WR_PRE    = SW'(CORE_LAT);
  localparam logic [SW-1:0] S_WR_STOP   = SW'(NPIX + CORE_LAT);
  localparam logic [SW-1:0] S_DONE_PRE  = SW'(NPIX + CORE_LAT - 1);
  localparam logic [SW-1:0] S_THR_LAST  = SW'(NPIX);

  state_t        state;
  logic [SW-1:0] s;
  logic          busy;
  logic          done;
  logic          img_rd;
  logic          ate_reset;
  logic          res_we;
  logic          thr_we;
  logic          streaming_c;
  logic          rd_last_c;
  logic          wr_last_c;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_blk;
  logic [BW-1:0] unused_rd_blk;

  assign streaming_c = (state == FEED) || (state == DRAIN);

  // Strobes are scheduled one cycle ahead from the stream counter s (s = 0 on the first FEED cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      img_rd    <= 1'b0;
      ate_reset <= 1'b1;
      res_we    <= 1'b0;
      thr_we    <= 1'b0;
    end else begin
      res_we <= streaming_c && (s >= S_WR_PRE) && (s < S_WR_STOP);
      thr_we <= streaming_c && (s >= S_WR_PRE) && (s <= S_THR_LAST) && (s[5:0] == 6'd0);
      done   <= streaming_c && (s == S_DONE_PRE);
      case (state)
        IDLE: begin
          s <= '0;
          if (bus.start) begin
            state  <= ALIGN;
            busy   <= 1'b1;
            img_rd <= 1'b1;
          end
        end
        ALIGN: begin
          state     <= FEED;
          ate_reset <= 1'b0;
        end
        FEED: begin
          s      <= s + SW'(1);
          img_rd <= img_rd && !rd_last_c;
          if (s == S_FEED_LAST) state <= DRAIN;
        end
        DRAIN: begin
          s <= s + SW'(1);
          if (res_we && wr_last_c) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ate_reset <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ate_blk_addr_gen #(.BLK_W(BLK_W), .BLK_H(BLK_H), .AW(AW), .BW(BW)) u_rd_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .step     (img_rd),
    .addr     (rd_addr),
    .blk      (unused_rd_blk),
    .at_last_c(rd_last_c)
  );

  // Second walker trails the reads by the core latency and addresses the write-back.
  ate_blk_addr_gen #(.BLK_W(BLK_W), .BLK_H(BLK_H), .AW(AW), .BW(BW)) u_wr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .step     (res_we),
    .addr     (wr_addr),
    .blk      (wr_blk),
    .at_last_c(wr_last_c)
  );

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.img_rd    = img_rd;
  assign bus.img_addr  = rd_addr;
  assign bus.ate_reset = ate_reset;
  assign bus.ate_pix   = (state == FEED) ? bus.img_data : '0;
  assign bus.res_we    = res_we;
  assign bus.res_addr  = wr_addr;
  assign bus.res_data  = bus.ate_bin;
  assign bus.thr_we    = thr_we;
  assign bus.thr_addr  = wr_blk;
  assign bus.thr_data  = bus.ate_thr;
endmodule

// File: tb/tb_ate_frame_ctrl.sv
// Bench for ate_frame_ctrl: a 2x1-block instance with an image memory and a behavioural core,
// plus a default 6x4 instance for the end-of-frame timing.
module tb_ate_frame_ctrl;
  localparam int NS   = 128;
  localparam int NV   = 13;
  localparam int DONE_S = NS + 64;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   mode;

  ate_frame_ctrl_if #(.AW(7),  .BW(1)) sm ();
  ate_frame_ctrl_if #(.AW(11), .BW(5)) big ();

  ate_frame_ctrl #(.BLK_W(2), .BLK_H(1), .AW(7), .BW(1)) dut_s (.clk(clk), .reset(reset), .bus(sm));
  ate_frame_ctrl #(.BLK_W(6), .BLK_H(4), .AW(11), .BW(5)) dut_b (.clk(clk), .reset(reset), .bus(big));

  typedef struct {
    int s; bit busy; bit ate_reset; bit img_rd; int img_addr; int ate_pix;
    bit res_we; int res_addr; bit thr_we; int thr_addr; bit done;
  } vec_t;
  vec_t tbl [NV];

  logic [7:0] hist [256];
  int ccnt;
  int acc;
  int res_cnt [NS];
  int res_val [NS];
  int thr_cnt [2];
  int thr_val [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix_of(input int a, input int md);
    return (md == 0) ? 8'(a) : 8'h80;
  endfunction

  function automatic int fbin(input logic [7:0] p);
    return int'(p[0] ^ p[3] ^ p[7]);
  endfunction

  function automatic int gold_thr(input int k, input int md);
    int sum = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) sum += int'(pix_of(r * 16 + 8 * k + c, md));
    return sum / 64;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Sync-read image memory for the small instance
  always @(posedge clk) if (sm.img_rd) sm.img_data <= pix_of(int'(sm.img_addr), mode);

  // Behavioural core: bin of pixel n appears after edge n+64, block mean after edge 64(k+1)
  always @(posedge clk) begin
    if (sm.ate_reset) begin
      ccnt <= 0;
      acc <= 0;
      sm.ate_bin <= 1'b0;
    end else begin
      hist[8'(ccnt)] <= sm.ate_pix;
      if (ccnt >= 64) sm.ate_bin <= fbin(hist[8'(ccnt - 64)]) != 0;
      if (ccnt % 64 == 0) begin
        if (ccnt >= 64) sm.ate_thr <= 8'(acc / 64);
        acc <= int'(sm.ate_pix);
      end else begin
        acc <= acc + int'(sm.ate_pix);
      end
      ccnt <= ccnt + 1;
    end
  end

  task automatic run_frame(input int md, input bit use_tbl, input int rst_at, input int s1, input int s2);
    int done_s = -100;
    int thr_total = 0;
    int bad_cov = 0;
    int bad_val = 0;
    bit aborted = 0;
    mode = md;
    for (int a = 0; a < NS; a++) begin res_cnt[a] = 0; res_val[a] = -1; end
    for (int k = 0; k < 2; k++) begin thr_cnt[k] = 0; thr_val[k] = -1; end
    @(posedge clk); #1 sm.start = 1'b1;
    @(posedge clk); #1 sm.start = 1'b0;
    for (int t = -1; t <= DONE_S + 4; t++) begin
      @(negedge clk);
      if (sm.res_we) begin res_cnt[int'(sm.res_addr)]++; res_val[int'(sm.res_addr)] = int'(sm.res_data); end
      if (sm.thr_we) begin thr_total++; thr_cnt[int'(sm.thr_addr)]++; thr_val[int'(sm.thr_addr)] = int'(sm.thr_data); end
      if (sm.done && done_s < 0) done_s = t;
      if (use_tbl)
        for (int i = 0; i < NV; i++)
          if (tbl[i].s == t) begin
            chk($sformatf("s%0d_busy", t), int'(sm.busy), int'(tbl[i].busy));
            chk($sformatf("s%0d_ate_reset", t), int'(sm.ate_reset), int'(tbl[i].ate_reset));
            chk($sformatf("s%0d_img_rd", t), int'(sm.img_rd), int'(tbl[i].img_rd));
            if (tbl[i].img_addr >= 0) chk($sformatf("s%0d_img_addr", t), int'(sm.img_addr), tbl[i].img_addr);
            if (tbl[i].ate_pix >= 0) chk($sformatf("s%0d_ate_pix", t), int'(sm.ate_pix), tbl[i].ate_pix);
            chk($sformatf("s%0d_res_we", t), int'(sm.res_we), int'(tbl[i].res_we));
            if (tbl[i].res_addr >= 0) chk($sformatf("s%0d_res_addr", t), int'(sm.res_addr), tbl[i].res_addr);
            chk($sformatf("s%0d_thr_we", t), int'(sm.thr_we), int'(tbl[i].thr_we));
            if (tbl[i].thr_addr >= 0) chk($sformatf("s%0d_thr_addr", t), int'(sm.thr_addr), tbl[i].thr_addr);
            chk($sformatf("s%0d_done", t), int'(sm.done), int'(tbl[i].done));
          end
      sm.start = (t == s1) || (t == s2);
      if (t == rst_at) reset = 1'b1;
      if (t == rst_at + 1) begin
        chk("abort_busy", int'(sm.busy), 0);
        chk("abort_res_we", int'(sm.res_we), 0);
        chk("abort_thr_we", int'(sm.thr_we), 0);
        chk("abort_ate_reset", int'(sm.ate_reset), 1);
        reset = 1'b0;
        aborted = 1;
        break;
      end
    end
    sm.start = 1'b0;
    if (!aborted) begin
      chk("done_cycle", done_s, DONE_S);
      chk("idle_after_frame", int'(sm.busy), 0);
      for (int a = 0; a < NS; a++) begin
        if (res_cnt[a] != 1) bad_cov++;
        if (res_val[a] != fbin(pix_of(a, md))) bad_val++;
      end
      chk("res_addr_cover", bad_cov, 0);
      chk("res_data_golden", bad_val, 0);
      chk("thr_we_count", thr_total, 2);
      for (int k = 0; k < 2; k++) chk($sformatf("thr_val%0d", k), thr_val[k], gold_thr(k, md));
    end
  endtask

  task automatic run_big();
    int thr_total = 0;
    int res_total = 0;
    int thr23_s = -1;
    int thr23_d = -1;
    int done_s = -1;
    int done_addr = -1;
    int done_we = -1;
    @(posedge clk); #1 big.start = 1'b1;
    @(posedge clk); #1 big.start = 1'b0;
    for (int t = -1; t <= 1536 + 70; t++) begin
      @(negedge clk);
      if (big.res_we) res_total++;
      if (big.thr_we) begin
        thr_total++;
        if (big.thr_addr == 5'd23) begin thr23_s = t; thr23_d = int'(big.thr_data); end
      end
      if (big.done && done_s < 0) begin
        done_s = t;
        done_addr = int'(big.res_addr);
        done_we = int'(big.res_we);
      end
    end
    chk("big_thr23_cycle", thr23_s, 1537);
    chk("big_thr23_data", thr23_d, 8'h5a);
    chk("big_thr_count", thr_total, 24);
    chk("big_res_count", res_total, 1536);
    chk("big_done_cycle", done_s, 1600);
    chk("big_done_res_addr", done_addr, 1535);
    chk("big_done_res_we", done_we, 1);
    chk("big_idle_after", int'(big.busy), 0);
  endtask

  initial begin
    int noisy = 0;
    checks = 0;
    errors = 0;
    mode = 0;
    reset = 1'b1;
    sm.start = 1'b0;
    sm.ate_thr = 8'h00;
    big.start = 1'b0;
    big.img_data = 8'h00;
    big.ate_bin = 1'b0;
    big.ate_thr = 8'h5a;

    //          s   busy rst rd  iaddr pix  rwe raddr twe taddr done
    tbl[0]  = '{-1,  1,  1,  1,  0,   -1,  0,  -1,   0,  -1,  0};
    tbl[1]  = '{0,   1,  0,  1,  1,    0,  0,  -1,   0,  -1,  0};
    tbl[2]  = '{7,   1,  0,  1,  16,   7,  0,  -1,   0,  -1,  0};
    tbl[3]  = '{63,  1,  0,  1,  8,  119,  0,  -1,   0,  -1,  0};
    tbl[4]  = '{64,  1,  0,  1,  9,    8,  0,  -1,   0,  -1,  0};
    tbl[5]  = '{65,  1,  0,  1,  10,   9,  1,   0,   1,   0,  0};
    tbl[6]  = '{126, 1,  0,  1,  127, 126, 1, 117,   0,  -1,  0};
    tbl[7]  = '{127, 1,  0,  0,  -1,  127, 1, 118,   0,  -1,  0};
    tbl[8]  = '{128, 1,  0,  0,  -1,   0,  1, 119,   0,  -1,  0};
    tbl[9]  = '{129, 1,  0,  0,  -1,   0,  1,   8,   1,   1,  0};
    tbl[10] = '{130, 1,  0,  0,  -1,   0,  1,   9,   0,  -1,  0};
    tbl[11] = '{192, 1,  0,  0,  -1,   0,  1, 127,   0,  -1,  1};
    tbl[12] = '{193, 0,  1,  0,  -1,   0,  0,  -1,   0,  -1,  0};

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(sm.busy), 0);
    chk("rst_done", int'(sm.done), 0);
    chk("rst_img_rd", int'(sm.img_rd), 0);
    chk("rst_res_we", int'(sm.res_we), 0);
    chk("rst_thr_we", int'(sm.thr_we), 0);
    chk("rst_ate_reset", int'(sm.ate_reset), 1);
    chk("rst_img_addr", int'(sm.img_addr), 0);
    chk("rst_res_addr", int'(sm.res_addr), 0);
    chk("rst_thr_addr", int'(sm.thr_addr), 0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sm.busy || !sm.ate_reset || sm.res_we || sm.thr_we || sm.done || sm.img_rd) noisy++;
    end
    chk("idle_quiet", noisy, 0);

    run_frame(0, 1'b1, -99, -99, -99);
    run_frame(1, 1'b0, -99, 50, DONE_S);
    run_frame(0, 1'b0, -99, -99, -99);
    run_frame(0, 1'b0, 100, -99, -99);
    run_frame(0, 1'b0, -99, -99, -99);
    run_big();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
